rtmc_spi_target: RTL and testbench
==================================

RTMC_SPI_TARGET -- requirements
Module: rtmc_spi_target

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports sck, cs_n and sdi, each input, 1, raw asynchronous SPI pins (mode 0, MSB first).
REQ-004 SHALL have port sdo, output, 1, serial response data.
REQ-005 SHALL have port bus_addr, output, 8, register address.
REQ-006 SHALL have port bus_wdata, output, 16, write data.
REQ-007 SHALL have port bus_we, output, 1, one-clk write strobe.
REQ-008 SHALL have port bus_re, output, 1, one-clk read strobe.
REQ-009 SHALL have port bus_rdata, input, 16, read data, combinationally valid in the bus_re cycle.
REQ-010 SHALL have port frame_err, output, 1, one-clk pulse on aborted frame.

Function
REQ-011 SHALL pass sck, cs_n and sdi through 2-FF synchronizers and detect sck rise/fall from the synchronized value; supported sck SHALL be at most clk/4.
REQ-012 SHALL sample sdi on each sync sck rise while cs_n is low; bit counter 3b, MSB first, byte complete on 8th rise.
REQ-013 SHALL run FSM states IDLE, OP, ADDR, WDATA, EXEC, RESP, DRAIN; cs_n fall moves IDLE->OP.
REQ-014 OP byte: 0x00 NOP->DRAIN; 0x01 read->ADDR; 0x02 write->ADDR; any other->RESP with RESULT 0xFF.
REQ-015 ADDR byte SHALL load bus_addr; read->EXEC; write->WDATA.
REQ-016 WDATA SHALL take 2 bytes, high byte first, into bus_wdata; after the 2nd byte->EXEC.
REQ-017 EXEC SHALL last exactly 1 clk and assert exactly one of bus_we or bus_re; on a read, {RESULT 0x02, bus_rdata} SHALL be captured into a 24b shift register in that clk. On a write, the shift register SHALL be loaded with {0x01, 16'h0}. Then ->RESP.
REQ-018 RESP SHALL shift the response MSB first: read 3 bytes, write 1 byte, error 1 byte; after the last bit ->DRAIN.
REQ-019 sdo SHALL change only on sync sck fall. The first response bit SHALL be driven on the sck fall following the final command bit (after the 8th rise).
REQ-020 sdo SHALL be 0 in IDLE, OP, ADDR, WDATA and DRAIN, so it reads as 0x00 BUSY.
REQ-021 DRAIN SHALL ignore further bytes and output 0x00 until cs_n rises.
REQ-022 Sync cs_n rise SHALL return to IDLE from any state and clear the bit counter.
REQ-023 A cs_n rise in ADDR/WDATA, or in OP with a partial byte, SHALL pulse frame_err and issue no bus strobe.
REQ-024 A cs_n rise in RESP with bits remaining SHALL pulse frame_err; the bus access has already occurred.
REQ-025 bus_addr and bus_wdata SHALL hold their last values between frames.
REQ-026 At most one bus strobe SHALL occur per cs_n-low frame.

Reset
REQ-027 rst_n low SHALL force the FSM to IDLE and clear all counters and shift registers.
REQ-028 rst_n low SHALL drive sdo=0, bus_addr=0x00, bus_wdata=0x0000, bus_we=0, bus_re=0 and frame_err=0.
REQ-029 Synchronizer flops SHALL reset cs_n to 1 and sck and sdi to 0.
REQ-030 Reset mid-frame SHALL issue no strobe; the frame resumes only after cs_n returns high and then low again.

Configuration
REQ-031 Macro RTMC_SPI_ADDR_CHECK_EN defined: addresses 0x0B-0x0F and >=0x20 SHALL skip EXEC, with no strobe, and return RESULT 0xFF, 1 byte. This check SHALL apply to writes of address 0x00-0x01 as well.
REQ-032 Macro RTMC_SPI_ADDR_CHECK_EN undefined: every address SHALL be forwarded to the bus unchecked.

Verification
REQ-033 Write frame 02 03 00 A5 + 1 dummy byte -> exactly one bus_we with bus_addr=0x03 and bus_wdata=0x00A5; sdo returns 0x01.
REQ-034 Read frame 01 10 + 3 dummy bytes with bus_rdata=0x1234 -> one bus_re with addr 0x10; sdo returns 02 12 34.
REQ-035 OP 0x7E + 1 dummy byte -> no strobe; sdo returns 0xFF; extra bytes return 0x00.
REQ-036 cs_n raised after 5 bits of the 3rd write byte -> frame_err pulse, no bus_we; next frame 01 05 reads correctly.
REQ-037 With RTMC_SPI_ADDR_CHECK_EN, frame 02 0C 12 34 -> no bus_we; response 0xFF. Without the macro -> bus_we with addr 0x0C.
REQ-038 rst_n asserted mid RESP -> sdo=0 immediately; no further strobe; post-reset write frame succeeds.

Source files
------------

// File: rtl/rtmc_spi_target_if.sv
// SPI pin and register-bus bundle for rtmc_spi_target.
// slave: the target side; master: the host/bus side.
interface rtmc_spi_target_if;
  logic        sck;
  logic        cs_n;
  logic        sdi;
  logic        sdo;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata;
  logic        frame_err;

  modport slave (
    input  sck, cs_n, sdi, bus_rdata,
    output sdo, bus_addr, bus_wdata,
    output bus_we, bus_re, frame_err
  );

  modport master (
    output sck, cs_n, sdi, bus_rdata,
    input  sdo, bus_addr, bus_wdata,
    input  bus_we, bus_re, frame_err
  );
endinterface

// File: rtl/rtmc_spi_target.sv
// SPI mode-0 target bridging byte commands to a register bus.
// Optional address range check: RTMC_SPI_ADDR_CHECK_EN.
module rtmc_spi_target (
  input  logic             clk,
  input  logic             rst_n,
  rtmc_spi_target_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_OP, S_ADDR, S_WDATA,
    S_EXEC, S_RESP, S_DRAIN
  } state_e;

  state_e      st_q, st_d;
  logic [1:0]  cs_sync_q, sck_sync_q, sdi_sync_q;
  logic        sck_prev_q;
  logic [1:0]  hi_q, hi_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [23:0] rsp_q, rsp_d;
  logic [4:0]  rbits_q, rbits_d;
  logic        sdo_q, sdo_d;
  logic        wr_q, wr_d;
  logic        hib_q, hib_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ferr_q, ferr_d;
  logic        we, re;

  logic cs_s, sck_s, sdi_s;
  logic sck_rise, sck_fall;
  logic [7:0] byte_v;
  logic byte_done;
  logic addr_bad;

  assign cs_s     = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign byte_v   = {sh_q, sdi_s};
  assign byte_done = sck_rise && !cs_s &&
                     (cnt_q == 3'd7) && (st_q != S_IDLE);

`ifdef RTMC_SPI_ADDR_CHECK_EN
  logic [7:0] chk_addr;
  assign chk_addr = (st_q == S_ADDR) ? byte_v : addr_q;
  assign addr_bad = (chk_addr >= 8'h0B && chk_addr <= 8'h0F) ||
                    (chk_addr >= 8'h20);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= 2'b11;
      sck_sync_q <= 2'b00;
      sdi_sync_q <= 2'b00;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[0], bus.cs_n};
      sck_sync_q <= {sck_sync_q[0], bus.sck};
      sdi_sync_q <= {sdi_sync_q[0], bus.sdi};
      sck_prev_q <= sck_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      hi_q    <= 2'd0;
      cnt_q   <= 3'd0;
      sh_q    <= 7'd0;
      rsp_q   <= 24'd0;
      rbits_q <= 5'd0;
      sdo_q   <= 1'b0;
      wr_q    <= 1'b0;
      hib_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rsp_q   <= rsp_d;
      rbits_q <= rbits_d;
      sdo_q   <= sdo_d;
      wr_q    <= wr_d;
      hib_q   <= hib_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rsp_d   = rsp_q;
    rbits_d = rbits_q;
    sdo_d   = sdo_q;
    wr_d    = wr_q;
    hib_d   = hib_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ferr_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    // cs must be seen high for 3 clks before a frame may start,
    // so a reset released mid-frame waits for a fresh cs_n fall
    hi_d = !cs_s ? 2'd0 :
           (hi_q == 2'd3) ? hi_q : hi_q + 2'd1;

    if (st_q != S_IDLE && sck_rise && !cs_s) begin
      sh_d  = byte_v[6:0];
      cnt_d = cnt_q + 3'd1;
    end

    unique case (st_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        sdo_d = 1'b0;
        if (!cs_s && hi_q == 2'd3) st_d = S_OP;
      end
      S_OP: begin
        if (byte_done) begin
          case (byte_v)
            8'h00: st_d = S_DRAIN;
            8'h01: begin wr_d = 1'b0; st_d = S_ADDR; end
            8'h02: begin wr_d = 1'b1; st_d = S_ADDR; end
            default: begin
              rsp_d   = {8'hFF, 16'h0000};
              rbits_d = 5'd8;
              st_d    = S_RESP;
            end
          endcase
        end
      end
      S_ADDR: begin
        if (byte_done) begin
          addr_d = byte_v;
          hib_d  = 1'b1;
          if (wr_q) st_d = S_WDATA;
          else if (addr_bad) begin
            rsp_d   = {8'hFF, 16'h0000};
            rbits_d = 5'd8;
            st_d    = S_RESP;
          end else st_d = S_EXEC;
        end
      end
      S_WDATA: begin
        if (byte_done) begin
          hib_d = 1'b0;
          if (hib_q) wdata_d[15:8] = byte_v;
          else begin
            wdata_d[7:0] = byte_v;
            if (addr_bad) begin
              rsp_d   = {8'hFF, 16'h0000};
              rbits_d = 5'd8;
              st_d    = S_RESP;
            end else st_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        we      = wr_q;
        re      = !wr_q;
        rsp_d   = wr_q ? {8'h01, 16'h0000}
                       : {8'h02, bus.bus_rdata};
        rbits_d = wr_q ? 5'd8 : 5'd24;
        st_d    = S_RESP;
      end
      S_RESP: begin
        if (sck_fall && rbits_q != 5'd0) begin
          sdo_d   = rsp_q[23];
          rsp_d   = {rsp_q[22:0], 1'b0};
          rbits_d = rbits_q - 5'd1;
        end else if (sck_rise && rbits_q == 5'd0) begin
          st_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sck_fall) sdo_d = 1'b0;
      end
    endcase

    if (cs_s && st_q != S_IDLE) begin
      st_d   = S_IDLE;
      cnt_d  = 3'd0;
      sdo_d  = 1'b0;
      ferr_d = (st_q == S_ADDR) || (st_q == S_WDATA) ||
               (st_q == S_EXEC) ||
               (st_q == S_OP && cnt_q != 3'd0) ||
               (st_q == S_RESP && rbits_q != 5'd0);
    end
  end

  assign bus.sdo       = sdo_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = we;
  assign bus.bus_re    = re;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_rtmc_spi_target.sv
// Randomized and directed bench for rtmc_spi_target.
// Expected bytes come from a frame-level command model.
module tb_rtmc_spi_target;
  localparam time HALF = 80ns;
`ifdef RTMC_SPI_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  rtmc_spi_target_if bif ();

  rtmc_spi_target dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5ns clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_tot = 0, re_tot = 0, ferr_tot = 0;
  logic [7:0]  we_addr, re_addr;
  logic [15:0] we_data;

  always @(negedge clk) begin
    if (bif.bus_we) begin
      we_tot  <= we_tot + 1;
      we_addr <= bif.bus_addr;
      we_data <= bif.bus_wdata;
    end
    if (bif.bus_re) begin
      re_tot  <= re_tot + 1;
      re_addr <= bif.bus_addr;
    end
    if (bif.frame_err) ferr_tot <= ferr_tot + 1;
  end

  logic [7:0] tx[$];
  logic [7:0] exp_rx[$];
  logic       exp_we, exp_re;
  logic [7:0] exp_addr;
  logic [15:0] exp_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_addr(input logic [7:0] a);
    return ADDR_CHK && ((a >= 8'h0B && a <= 8'h0F) || a >= 8'h20);
  endfunction

  // Command bytes, then response bytes, then extra dummies reading 0.
  task automatic build_expect(input logic [7:0] op, input logic [7:0] a,
                              input logic [15:0] wd, input logic [15:0] rd,
                              input int extra);
    logic [7:0] rsp[$];
    int ncmd;
    tx.delete();
    exp_rx.delete();
    exp_we = 1'b0;
    exp_re = 1'b0;
    exp_addr = a;
    exp_wd = wd;
    tx.push_back(op);
    if (op == 8'h01 || op == 8'h02) begin
      tx.push_back(a);
      if (op == 8'h02) begin
        tx.push_back(wd[15:8]);
        tx.push_back(wd[7:0]);
      end
      if (bad_addr(a)) rsp.push_back(8'hFF);
      else if (op == 8'h02) begin
        exp_we = 1'b1;
        rsp.push_back(8'h01);
      end else begin
        exp_re = 1'b1;
        rsp.push_back(8'h02);
        rsp.push_back(rd[15:8]);
        rsp.push_back(rd[7:0]);
      end
    end else if (op != 8'h00) begin
      rsp.push_back(8'hFF);
    end
    ncmd = tx.size();
    for (int i = 0; i < ncmd; i++) exp_rx.push_back(8'h00);
    for (int i = 0; i < rsp.size() + extra; i++) begin
      tx.push_back(8'($urandom));
      exp_rx.push_back(i < rsp.size() ? rsp[i] : 8'h00);
    end
    bif.bus_rdata = rd;
  endtask

  task automatic spi_xfer(input logic [7:0] d, input int nbits,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      bif.sdi = d[7-b];
      #HALF;
      rx = {rx[6:0], bif.sdo};
      bif.sck = 1'b1;
      #HALF;
      bif.sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag);
    logic [7:0] rx;
    int w0, r0, f0;
    w0 = we_tot; r0 = re_tot; f0 = ferr_tot;
    bif.cs_n = 1'b0;
    #40ns;
    for (int i = 0; i < tx.size(); i++) begin
      spi_xfer(tx[i], 8, rx);
      chk($sformatf("%s rx%0d", tag, i), 32'(rx), 32'(exp_rx[i]));
    end
    bif.cs_n = 1'b1;
    #100ns;
    chk({tag, " we"}, we_tot - w0, 32'(exp_we));
    chk({tag, " re"}, re_tot - r0, 32'(exp_re));
    chk({tag, " ferr"}, ferr_tot - f0, 0);
    chk({tag, " sdo idle"}, 32'(bif.sdo), 0);
    if (exp_we) begin
      chk({tag, " we addr"}, 32'(we_addr), 32'(exp_addr));
      chk({tag, " we data"}, 32'(we_data), 32'(exp_wd));
    end
    if (exp_re) chk({tag, " re addr"}, 32'(re_addr), 32'(exp_addr));
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] op;
    int w0, r0, f0;
    rst_n = 1'b0;
    bif.cs_n = 1'b1;
    bif.sck = 1'b0;
    bif.sdi = 1'b0;
    bif.bus_rdata = 16'h0000;
    #23ns;
    chk("rst sdo", 32'(bif.sdo), 0);
    chk("rst addr", 32'(bif.bus_addr), 0);
    chk("rst wdata", 32'(bif.bus_wdata), 0);
    chk("rst we", 32'(bif.bus_we), 0);
    chk("rst re", 32'(bif.bus_re), 0);
    chk("rst ferr", 32'(bif.frame_err), 0);
    rst_n = 1'b1;
    #100ns;

    build_expect(8'h02, 8'h03, 16'h00A5, 16'h0000, 0);
    run_frame("wr03");
    chk("hold addr", 32'(bif.bus_addr), 32'h03);
    chk("hold wdata", 32'(bif.bus_wdata), 32'h00A5);

    build_expect(8'h01, 8'h10, 16'h0000, 16'h1234, 0);
    run_frame("rd10");
    build_expect(8'h7E, 8'h00, 16'h0000, 16'h0000, 2);
    run_frame("op7E");
    build_expect(8'h00, 8'h00, 16'h0000, 16'h0000, 2);
    run_frame("nop");
    build_expect(8'h02, 8'h0C, 16'h1234, 16'h0000, 0);
    run_frame("wr0C");

    // abort after 5 bits of the first write data byte
    w0 = we_tot; f0 = ferr_tot;
    bif.cs_n = 1'b0;
    #40ns;
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h07, 8, rx);
    spi_xfer(8'h55, 5, rx);
    bif.cs_n = 1'b1;
    #100ns;
    chk("abort wd ferr", ferr_tot - f0, 1);
    chk("abort wd we", we_tot - w0, 0);
    build_expect(8'h01, 8'h05, 16'h0000, 16'hC3A1, 0);
    run_frame("rd05");

    // abort with a partial opcode byte
    f0 = ferr_tot; w0 = we_tot; r0 = re_tot;
    bif.cs_n = 1'b0;
    #40ns;
    spi_xfer(8'h01, 3, rx);
    bif.cs_n = 1'b1;
    #100ns;
    chk("abort op ferr", ferr_tot - f0, 1);
    chk("abort op strobes", (we_tot - w0) + (re_tot - r0), 0);

    // abort after the first of three read response bytes
    f0 = ferr_tot; r0 = re_tot;
    bif.bus_rdata = 16'h5A5A;
    bif.cs_n = 1'b0;
    #40ns;
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h06, 8, rx);
    spi_xfer(8'h00, 8, rx);
    chk("abort rsp byte", 32'(rx), 32'h02);
    bif.cs_n = 1'b1;
    #100ns;
    chk("abort rsp ferr", ferr_tot - f0, 1);
    chk("abort rsp re", re_tot - r0, 1);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        default: op = 8'($urandom_range(3, 255));
      endcase
      build_expect(op, 8'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)));
      run_frame($sformatf("rnd%0d op%0h", n, op));
    end

    // reset in the middle of a read response
    bif.bus_rdata = 16'hFFFF;
    bif.cs_n = 1'b0;
    #40ns;
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h05, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 3, rx);
    #50ns;
    chk("pre-rst sdo", 32'(bif.sdo), 1);
    rst_n = 1'b0;
    #1ns;
    chk("mid-rst sdo", 32'(bif.sdo), 0);
    #29ns;
    rst_n = 1'b1;
    w0 = we_tot; r0 = re_tot; f0 = ferr_tot;
    spi_xfer(8'h02, 8, rx);
    chk("post-rst rx0", 32'(rx), 0);
    spi_xfer(8'h01, 8, rx);
    chk("post-rst rx1", 32'(rx), 0);
    bif.cs_n = 1'b1;
    #100ns;
    chk("post-rst strobes", (we_tot - w0) + (re_tot - r0), 0);
    chk("post-rst ferr", ferr_tot - f0, 0);
    build_expect(8'h02, 8'h04, 16'hBEEF, 16'h0000, 1);
    run_frame("wr04 after rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
